// File: rtl/instruction_fetch_if.sv
// Fetch unit bus/decoder bundle: word read request to memory plus instruction handshake to decode.
// master = fetch unit, slave = memory and decoder side.
interface instruction_fetch_if;
   logic [31:0] busAddress;
   logic        busReadEnable;
   logic        busReady;
   logic [31:0] busDataIn;
   logic [31:0] instrOut;
   logic [31:0] instrPc;
   logic        instrValid;
   logic        instrReady;

   modport master (
      output busAddress, busReadEnable, instrOut, instrPc, instrValid,
      input  busReady, busDataIn, instrReady
   );

   modport slave (
      input  busAddress, busReadEnable, instrOut, instrPc, instrValid,
      output busReady, busDataIn, instrReady
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: one word read in flight, result held for the decoder until accepted; IDLE->valid is
// 2 cycles + memory wait states, decoder backpressure holds HOLD. Optional macro FETCH_ALIGN_CHECK_EN.
module instruction_fetch #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic        pcCountEnable,
   output logic        busError,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic        misalignFault,
`endif
   instruction_fetch_if.master fetchIf
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t      state, stateNext;
   logic [31:0] busAddressQ, busAddressNext;
   logic [31:0] instrOutQ, instrOutNext;
   logic [31:0] instrPcQ, instrPcNext;
   logic        busReadEnableQ, busReadEnableNext;
   logic        instrValidQ, instrValidNext;
   logic        pcCountEnableQ, pcCountEnableNext;
   logic        busErrorQ, busErrorNext;
   logic [7:0]  waitCount, waitCountNext;
   logic [31:0] fetchAddress;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalignQ, misalignNext;
`endif

   // While the advance pulse is high the pc register has not yet taken it, so step past it here.
   assign fetchAddress = (pcCountEnableQ ? pc + 32'd4 : pc) & 32'hFFFF_FFFC;

   always_comb begin
      stateNext         = state;
      busAddressNext    = busAddressQ;
      busReadEnableNext = busReadEnableQ;
      instrOutNext      = instrOutQ;
      instrPcNext       = instrPcQ;
      instrValidNext    = instrValidQ;
      pcCountEnableNext = 1'b0;
      busErrorNext      = busErrorQ;
      waitCountNext     = waitCount;
`ifdef FETCH_ALIGN_CHECK_EN
      misalignNext      = misalignQ;
`endif

      if (flush) begin
         stateNext         = IDLE;
         busReadEnableNext = 1'b0;
         instrValidNext    = 1'b0;
         busErrorNext      = 1'b0;
         waitCountNext     = 8'd0;
`ifdef FETCH_ALIGN_CHECK_EN
         misalignNext      = 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef FETCH_ALIGN_CHECK_EN
               if (pc[1:0] != 2'b00) begin
                  stateNext    = ERROR;
                  misalignNext = 1'b1;
               end else begin
                  busAddressNext    = fetchAddress;
                  busReadEnableNext = 1'b1;
                  stateNext         = FETCH;
               end
`else
               busAddressNext    = fetchAddress;
               busReadEnableNext = 1'b1;
               stateNext         = FETCH;
`endif
            end

            FETCH: begin
               if (fetchIf.busReady) begin
                  instrOutNext      = fetchIf.busDataIn;
                  instrPcNext       = busAddressQ;
                  instrValidNext    = 1'b1;
                  busReadEnableNext = 1'b0;
                  pcCountEnableNext = 1'b1;
                  waitCountNext     = 8'd0;
                  stateNext         = HOLD;
               end else if (waitCount >= TIMEOUT_LIMIT - 8'd1) begin
                  // Park the counter at the limit so it can never wrap.
                  busReadEnableNext = 1'b0;
                  busErrorNext      = 1'b1;
                  waitCountNext     = TIMEOUT_LIMIT;
                  stateNext         = ERROR;
               end else begin
                  waitCountNext = waitCount + 8'd1;
               end
            end

            HOLD: begin
               if (fetchIf.instrReady) begin
                  instrValidNext    = 1'b0;
                  busAddressNext    = fetchAddress;
                  busReadEnableNext = 1'b1;
                  stateNext         = FETCH;
               end
            end

            ERROR: begin
               busReadEnableNext = 1'b0;
               instrValidNext    = 1'b0;
            end

            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         busAddressQ    <= 32'd0;
         busReadEnableQ <= 1'b0;
         instrOutQ      <= 32'd0;
         instrPcQ       <= 32'd0;
         instrValidQ    <= 1'b0;
         pcCountEnableQ <= 1'b0;
         busErrorQ      <= 1'b0;
         waitCount      <= 8'd0;
`ifdef FETCH_ALIGN_CHECK_EN
         misalignQ      <= 1'b0;
`endif
      end else begin
         state          <= stateNext;
         busAddressQ    <= busAddressNext;
         busReadEnableQ <= busReadEnableNext;
         instrOutQ      <= instrOutNext;
         instrPcQ       <= instrPcNext;
         instrValidQ    <= instrValidNext;
         pcCountEnableQ <= pcCountEnableNext;
         busErrorQ      <= busErrorNext;
         waitCount      <= waitCountNext;
`ifdef FETCH_ALIGN_CHECK_EN
         misalignQ      <= misalignNext;
`endif
      end
   end

   assign fetchIf.busAddress    = busAddressQ;
   assign fetchIf.busReadEnable = busReadEnableQ;
   assign fetchIf.instrOut      = instrOutQ;
   assign fetchIf.instrPc       = instrPcQ;
   assign fetchIf.instrValid    = instrValidQ;
   assign pcCountEnable         = pcCountEnableQ;
   assign busError              = busErrorQ;
`ifdef FETCH_ALIGN_CHECK_EN
   assign misalignFault         = misalignQ;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory responses push expected {pc, word} to a scoreboard
// that is popped when the instruction is presented to the decoder.
module tb_instruction_fetch;
   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        pcCountEnable;
   logic        busError;
   logic [31:0] pc;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalignFault;
`endif

   int checks = 0;
   int errors = 0;
   int pcePulses = 0;
   int p0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } expInstr_t;
   expInstr_t expQ[$];

   instruction_fetch_if bus();

   instruction_fetch #(.TIMEOUT_CYCLES(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .pc            (pc),
      .flush         (flush),
      .pcCountEnable (pcCountEnable),
      .busError      (busError),
`ifdef FETCH_ALIGN_CHECK_EN
      .misalignFault (misalignFault),
`endif
      .fetchIf       (bus)
   );

   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock; the pc register model advances on the pulse seen before the edge.
   task automatic tick();
      logic pceBefore;
      pceBefore = pcCountEnable;
      @(posedge clk);
      #1;
      if (pceBefore === 1'b1) pc = pc + 32'd4;
      if (pcCountEnable === 1'b1) pcePulses++;
   endtask

   // Taken jump: flush for one edge, pc register loads the target on that edge.
   task automatic jump(input logic [31:0] newPc);
      flush = 1'b1;
      tick();
      pc    = newPc;
      flush = 1'b0;
   endtask

   task automatic popCompare(input string tag);
      expInstr_t e;
      check1({tag, "_sbNotEmpty"}, expQ.size() != 0, 1'b1);
      if (expQ.size() != 0) begin
         e = expQ.pop_front();
         check32({tag, "_instrOut"}, bus.instrOut, e.data);
         check32({tag, "_instrPc"}, bus.instrPc, e.addr);
      end
   endtask

   // DUT must be in FETCH for expAddr; respond after `waits` idle cycles.
   task automatic serveFetch(input int waits, input logic [31:0] data,
                             input logic [31:0] expAddr, input string tag);
      expInstr_t e;
      check1({tag, "_req"}, bus.busReadEnable, 1'b1);
      check32({tag, "_addr"}, bus.busAddress, expAddr);
      for (int w = 0; w < waits; w++) begin
         tick();
         check1({tag, "_waitReq"}, bus.busReadEnable, 1'b1);
         check32({tag, "_waitAddr"}, bus.busAddress, expAddr);
      end
      bus.busReady  = 1'b1;
      bus.busDataIn = data;
      e.addr = expAddr;
      e.data = data;
      expQ.push_back(e);
      tick();
      bus.busReady  = 1'b0;
      bus.busDataIn = $urandom();
      check1({tag, "_pce"}, pcCountEnable, 1'b1);
      check1({tag, "_valid"}, bus.instrValid, 1'b1);
      check1({tag, "_reqDrop"}, bus.busReadEnable, 1'b0);
      popCompare(tag);
   endtask

   initial begin
      reset          = 1'b0;
      flush          = 1'b0;
      pc             = 32'd0;
      bus.busReady   = 1'b0;
      bus.busDataIn  = 32'd0;
      bus.instrReady = 1'b0;

      // Reset state
      tick();
      check32("rst_busAddress", bus.busAddress, 32'd0);
      check1("rst_busReadEnable", bus.busReadEnable, 1'b0);
      check32("rst_instrOut", bus.instrOut, 32'd0);
      check32("rst_instrPc", bus.instrPc, 32'd0);
      check1("rst_instrValid", bus.instrValid, 1'b0);
      check1("rst_pce", pcCountEnable, 1'b0);
      check1("rst_busError", busError, 1'b0);
      reset = 1'b1;
      tick();
      serveFetch(0, 32'h0000_0013, 32'h0, "first");

      // HOLD keeps data stable without acceptance; stray busReady ignored
      tick();
      tick();
      check1("hold_valid", bus.instrValid, 1'b1);
      check32("hold_instrOut", bus.instrOut, 32'h0000_0013);
      check1("hold_pceSingle", pcCountEnable, 1'b0);
      check1("hold_noReq", bus.busReadEnable, 1'b0);
      bus.busReady  = 1'b1;
      bus.busDataIn = 32'hBAD0_BAD0;
      tick();
      bus.busReady  = 1'b0;
      check32("stray_instrOut", bus.instrOut, 32'h0000_0013);
      check1("stray_pce", pcCountEnable, 1'b0);

      // Three wait states
      jump(32'h100);
      check1("jump_validDrop", bus.instrValid, 1'b0);
      check1("jump_noReq", bus.busReadEnable, 1'b0);
      tick();
      p0 = pcePulses;
      serveFetch(3, 32'h0050_0093, 32'h100, "wait3");
      check32("wait3_pulses", 32'(pcePulses - p0), 32'd1);

      // Back-to-back stream with decoder always ready
      jump(32'h4);
      tick();
      bus.instrReady = 1'b1;
      p0 = pcePulses;
      for (int i = 0; i < 4; i++) begin
         serveFetch(0, 32'h0010_0013 + 32'(i << 7), 32'h4 + 32'(4 * i), "stream");
         if (i < 3) tick();
      end
      bus.instrReady = 1'b0;
      check32("stream_pulses", 32'(pcePulses - p0), 32'd4);

      // Flush coincident with busReady
      bus.instrReady = 1'b1;
      tick();
      bus.instrReady = 1'b0;
      check32("preFlush_addr", bus.busAddress, 32'h14);
      p0 = pcePulses;
      flush         = 1'b1;
      bus.busReady  = 1'b1;
      bus.busDataIn = 32'hDEAD_BEEF;
      tick();
      pc            = 32'hC;
      flush         = 1'b0;
      bus.busReady  = 1'b0;
      check1("flush_noValid", bus.instrValid, 1'b0);
      check1("flush_noPce", pcCountEnable, 1'b0);
      check1("flush_noReq", bus.busReadEnable, 1'b0);
      check32("flush_dataKept", bus.instrOut, 32'h0010_0193);
      check32("flush_pulses", 32'(pcePulses - p0), 32'd0);
      tick();
      serveFetch(1, 32'h00C0_0113, 32'hC, "postFlush");

      // Timeout with TIMEOUT_CYCLES=4
      bus.instrReady = 1'b1;
      tick();
      bus.instrReady = 1'b0;
      check32("to_addr", bus.busAddress, 32'h10);
      p0 = pcePulses;
      for (int w = 0; w < 3; w++) begin
         tick();
         check1("to_earlyErr", busError, 1'b0);
         check1("to_earlyReq", bus.busReadEnable, 1'b1);
      end
      tick();
      check1("to_busError", busError, 1'b1);
      check1("to_reqDrop", bus.busReadEnable, 1'b0);
      check1("to_noValid", bus.instrValid, 1'b0);
      bus.busReady = 1'b1;
      tick();
      tick();
      bus.busReady = 1'b0;
      check1("err_sticky", busError, 1'b1);
      check1("err_noValid", bus.instrValid, 1'b0);
      check1("err_noReq", bus.busReadEnable, 1'b0);
      check32("err_pulses", 32'(pcePulses - p0), 32'd0);
      jump(32'h200);
      check1("err_flushClears", busError, 1'b0);
      tick();
      serveFetch(0, 32'h0020_0213, 32'h200, "afterErr");

      // Flush beats timeout on the same edge and clears the counter
      bus.instrReady = 1'b1;
      tick();
      bus.instrReady = 1'b0;
      check32("race_addr", bus.busAddress, 32'h204);
      tick();
      tick();
      tick();
      jump(32'h300);
      check1("race_noErr", busError, 1'b0);
      check1("race_noReq", bus.busReadEnable, 1'b0);
      tick();
      serveFetch(3, 32'h0030_0313, 32'h300, "cntCleared");

      // Flush while HOLD
      jump(32'h400);
      check1("holdFlush_noValid", bus.instrValid, 1'b0);
      tick();
      check32("holdFlush_addr", bus.busAddress, 32'h400);

      // Reset mid-FETCH beats flush and busReady
      reset         = 1'b0;
      flush         = 1'b1;
      bus.busReady  = 1'b1;
      bus.busDataIn = 32'h0000_1234;
      p0 = pcePulses;
      tick();
      check32("midRst_addr", bus.busAddress, 32'd0);
      check1("midRst_req", bus.busReadEnable, 1'b0);
      check1("midRst_valid", bus.instrValid, 1'b0);
      check32("midRst_instrOut", bus.instrOut, 32'd0);
      check32("midRst_instrPc", bus.instrPc, 32'd0);
      check32("midRst_pulses", 32'(pcePulses - p0), 32'd0);
      reset        = 1'b1;
      flush        = 1'b0;
      bus.busReady = 1'b0;
      pc           = 32'h40;
      tick();
      serveFetch(0, 32'h0040_0413, 32'h40, "afterRst");

      // Misaligned pc
      jump(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
      tick();
      check1("mis_fault", misalignFault, 1'b1);
      check1("mis_noBusErr", busError, 1'b0);
      check1("mis_noReq", bus.busReadEnable, 1'b0);
      tick();
      check1("mis_stillNoReq", bus.busReadEnable, 1'b0);
      jump(32'h100);
      check1("mis_flushClears", misalignFault, 1'b0);
      tick();
      serveFetch(0, 32'h0050_0513, 32'h100, "misRecover");
`else
      tick();
      serveFetch(0, 32'h0050_0513, 32'h100, "alignForce");
`endif

      check32("sb_empty", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
